// File: rtl/vga_cfg_sequencer_pkg.sv
// rtl/vga_cfg_sequencer_pkg.sv - shared defaults and state encoding for the VGA config sequencer
package vga_cfg_sequencer_pkg;

    localparam int CONFIG_WIDTH_DEF = 4;
    localparam int TIMEOUT_DEF      = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEQ  = 2'd1,
        ST_HOST = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/vga_cfg_table.sv
// rtl/vga_cfg_table.sv - address/data register file, one sync write port, one comb read port
module vga_cfg_table #(
    parameter int CONFIG_WIDTH = 4,
    parameter int ENTRIES      = 8,
    parameter int IDX_W        = $clog2(ENTRIES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [CONFIG_WIDTH-1:0] wr_addr,
    input  logic [CONFIG_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [CONFIG_WIDTH-1:0] rd_addr,
    output logic [CONFIG_WIDTH-1:0] rd_data
);

    logic [CONFIG_WIDTH-1:0] addr_mem [ENTRIES];
    logic [CONFIG_WIDTH-1:0] data_mem [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (we) begin
            addr_mem[wr_idx] <= wr_addr;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_addr = addr_mem[rd_idx];
    assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/vga_cfg_sequencer.sv
// rtl/vga_cfg_sequencer.sv - table-driven VGA config writer with host arbitration and stall timeout
module vga_cfg_sequencer
    import vga_cfg_sequencer_pkg::*;
#(
    parameter int CONFIG_WIDTH = CONFIG_WIDTH_DEF,
    parameter int ENTRIES      = 8,
    parameter int IDX_W        = $clog2(ENTRIES),
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [IDX_W:0]          tbl_len,
    input  logic                    tbl_we,
    input  logic [IDX_W-1:0]        tbl_idx,
    input  logic [CONFIG_WIDTH-1:0] tbl_addr,
    input  logic [CONFIG_WIDTH-1:0] tbl_data,
    input  logic                    host_valid,
    input  logic [CONFIG_WIDTH-1:0] host_addr,
    input  logic [CONFIG_WIDTH-1:0] host_data,
    output logic                    host_ready,
    output logic                    c_valid,
    output logic [CONFIG_WIDTH-1:0] c_addr,
    output logic [CONFIG_WIDTH-1:0] c_data,
    input  logic                    c_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int             CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W:0] LEN_MAX = (IDX_W + 1)'(ENTRIES);

    state_t                  state_q, state_d;
    logic [IDX_W:0]          idx_q, len_q, idx_nxt, len_sat;
    logic [CNT_W-1:0]        tmo_cnt_q;
    logic [IDX_W-1:0]        rd_idx;
    logic [CONFIG_WIDTH-1:0] rd_addr, rd_data;
    logic                    xfer, stall, tmo, seq_last, host_take;

    assign idx_nxt   = idx_q + 1'b1;
    assign len_sat   = (tbl_len > LEN_MAX) ? LEN_MAX : tbl_len;
    assign xfer      = c_valid & c_ready;
    assign stall     = c_valid & ~c_ready;
    assign tmo       = stall && (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
    assign seq_last  = (idx_nxt == len_q);
    // host_ready is only ever high in IDLE; masking avoids re-accepting a request the host is still dropping
    assign host_take = host_valid & ~host_ready;
    assign rd_idx    = (state_q == ST_IDLE) ? '0 : idx_nxt[IDX_W-1:0];
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);

    vga_cfg_table #(
        .CONFIG_WIDTH (CONFIG_WIDTH),
        .ENTRIES      (ENTRIES),
        .IDX_W        (IDX_W)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (tbl_we & ~busy),
        .wr_idx  (tbl_idx),
        .wr_addr (tbl_addr),
        .wr_data (tbl_data),
        .rd_idx  (rd_idx),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start)          state_d = (len_sat == '0) ? ST_FIN : ST_SEQ;
                else if (host_take) state_d = ST_HOST;
            end
            ST_SEQ:  if ((xfer && seq_last) || tmo) state_d = ST_FIN;
            ST_HOST: if (xfer || tmo) state_d = ST_IDLE;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            len_q      <= '0;
            tmo_cnt_q  <= '0;
            c_valid    <= 1'b0;
            c_addr     <= '0;
            c_data     <= '0;
            host_ready <= 1'b0;
            err        <= 1'b0;
        end else begin
            host_ready <= 1'b0;
            tmo_cnt_q  <= (!stall || tmo) ? '0 : tmo_cnt_q + 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        len_q <= len_sat;
                        idx_q <= '0;
                        err   <= 1'b0;
                        if (len_sat != '0) begin
                            c_valid <= 1'b1;
                            c_addr  <= rd_addr;
                            c_data  <= rd_data;
                        end
                    end else if (host_take) begin
                        c_valid <= 1'b1;
                        c_addr  <= host_addr;
                        c_data  <= host_data;
                    end
                end
                ST_SEQ: begin
                    if (tmo) begin
                        c_valid <= 1'b0;
                        err     <= 1'b1;
                    end else if (xfer) begin
                        idx_q <= idx_nxt;
                        if (seq_last) begin
                            c_valid <= 1'b0;
                        end else begin
                            c_addr <= rd_addr;
                            c_data <= rd_data;
                        end
                    end
                end
                ST_HOST: begin
                    if (tmo || xfer) begin
                        c_valid    <= 1'b0;
                        host_ready <= 1'b1;
                        if (tmo) err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_cfg_sequencer.sv
// tb/tb_vga_cfg_sequencer.sv - scoreboard bench for vga_cfg_sequencer
module tb_vga_cfg_sequencer;

    localparam int CW      = 4;
    localparam int ENTRIES = 8;
    localparam int IDX_W   = 3;
    localparam int TMO     = 8;

    localparam int K_XFER = 0;
    localparam int K_DONE = 1;
    localparam int K_HRDY = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [IDX_W:0]  tbl_len = '0;
    logic            tbl_we = 1'b0;
    logic [IDX_W-1:0] tbl_idx = '0;
    logic [CW-1:0]   tbl_addr = '0, tbl_data = '0;
    logic            host_valid = 1'b0;
    logic [CW-1:0]   host_addr = '0, host_data = '0;
    logic            host_ready;
    logic            c_valid;
    logic [CW-1:0]   c_addr, c_data;
    logic            c_ready = 1'b0;
    logic            busy, done, err;

    vga_cfg_sequencer #(
        .CONFIG_WIDTH (CW),
        .ENTRIES      (ENTRIES),
        .IDX_W        (IDX_W),
        .TIMEOUT      (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .tbl_len    (tbl_len),
        .tbl_we     (tbl_we),
        .tbl_idx    (tbl_idx),
        .tbl_addr   (tbl_addr),
        .tbl_data   (tbl_data),
        .host_valid (host_valid),
        .host_addr  (host_addr),
        .host_data  (host_data),
        .host_ready (host_ready),
        .c_valid    (c_valid),
        .c_addr     (c_addr),
        .c_data     (c_data),
        .c_ready    (c_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [CW-1:0] a;
        logic [CW-1:0] d;
        logic        e;
        int          vc;
    } ev_t;

    ev_t           exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] m_a [ENTRIES];
    logic [CW-1:0] m_d [ENTRIES];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_x(input logic [CW-1:0] a, input logic [CW-1:0] d);
        ev_t e;
        e.kind = K_XFER; e.a = a; e.d = d; e.e = 1'b0; e.vc = 0;
        exp_q.push_back(e);
    endtask

    task automatic push_end(input int kind, input logic e_err, input int vc);
        ev_t e;
        e.kind = kind; e.a = '0; e.d = '0; e.e = e_err; e.vc = vc;
        exp_q.push_back(e);
    endtask

    task automatic push_seq(input int len, input logic e_err, input int vc);
        int n;
        n = (len > ENTRIES) ? ENTRIES : len;
        for (int i = 0; i < n; i++) push_x(m_a[i], m_d[i]);
        push_end(K_DONE, e_err, vc);
    endtask

    task automatic write_tbl(input int idx, input logic [CW-1:0] a, input logic [CW-1:0] d);
        tbl_we = 1'b1; tbl_idx = IDX_W'(idx); tbl_addr = a; tbl_data = d;
        tick();
        tbl_we = 1'b0;
        m_a[idx] = a; m_d[idx] = d;
    endtask

    task automatic start_seq(input int len);
        start = 1'b1; tbl_len = (IDX_W + 1)'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        chk({name, "_idle_timeout"}, int'(busy), 0);
    endtask

    task automatic wait_host_ready(input string name);
        int n;
        n = 0;
        while (!host_ready && n < 60) begin
            tick();
            n++;
        end
        chk({name, "_host_ready_seen"}, int'(host_ready), 1);
        host_valid = 1'b0;
    endtask

    // Monitor: pops one expected event per observed DUT event and tracks valid cycles and hold stability
    int            vcount = 0;
    logic          prev_stall = 1'b0;
    logic [CW-1:0] prev_a = '0, prev_d = '0;

    task automatic pop_check(input int kind, input string name);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event kind=%0d addr=%0d data=%0d err=%0d vcyc=%0d",
                     name, kind, c_addr, c_data, err, vcount);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind ||
            (kind == K_XFER && (c_addr != e.a || c_data != e.d)) ||
            (kind != K_XFER && (err != e.e || vcount != e.vc))) begin
            errors++;
            $display("FAIL %s: got kind=%0d addr=%0d data=%0d err=%0d vcyc=%0d expected kind=%0d addr=%0d data=%0d err=%0d vcyc=%0d",
                     name, kind, c_addr, c_data, err, vcount, e.kind, e.a, e.d, e.e, e.vc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            vcount     = 0;
            prev_stall = 1'b0;
        end else begin
            if (c_valid) vcount++;
            if (prev_stall && c_valid) begin
                checks++;
                if (c_addr != prev_a || c_data != prev_d) begin
                    errors++;
                    $display("FAIL hold_stable: got %0d/%0d expected %0d/%0d", c_addr, c_data, prev_a, prev_d);
                end
            end
            if (c_valid && c_ready) pop_check(K_XFER, "xfer");
            if (done) begin
                pop_check(K_DONE, "done");
                vcount = 0;
            end
            if (host_ready) begin
                pop_check(K_HRDY, "host_ready");
                vcount = 0;
            end
            prev_stall = c_valid && !c_ready;
            prev_a     = c_addr;
            prev_d     = c_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < ENTRIES; i++) begin
            m_a[i] = '0; m_d[i] = '0;
        end
        tick();
        tick();
        chk("rst_c_valid", int'(c_valid), 0);
        chk("rst_c_addr", int'(c_addr), 0);
        chk("rst_c_data", int'(c_data), 0);
        chk("rst_host_ready", int'(host_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;
        tick();

        write_tbl(0, 4'b1011, 4'b0010);
        write_tbl(1, 4'b1000, 4'b0001);
        write_tbl(2, 4'b0011, 4'b0011);

        // Basic three-entry run, no back-pressure
        c_ready = 1'b1;
        push_seq(3, 1'b0, 3);
        start_seq(3);
        chk("start_busy", int'(busy), 1);
        chk("start_c_valid", int'(c_valid), 1);
        chk("start_c_addr", int'(c_addr), 11);
        wait_idle("basic");

        // Entry 1 stalled for 4 cycles: held 5 cycles, 7 valid cycles total
        push_seq(3, 1'b0, 7);
        start_seq(3);
        tick();
        c_ready = 1'b0;
        repeat (4) tick();
        c_ready = 1'b1;
        wait_idle("stall");

        // Timeout mid-sequence, then a new start clears err
        c_ready = 1'b0;
        push_seq(0, 1'b1, 8);
        start_seq(2);
        wait_idle("timeout");
        chk("timeout_err_sticky", int'(err), 1);
        c_ready = 1'b1;
        push_seq(1, 1'b0, 1);
        start_seq(1);
        chk("start_clears_err", int'(err), 0);
        wait_idle("after_timeout");

        // start and host_valid together: sequence first, host afterwards
        host_valid = 1'b1; host_addr = 4'b1011; host_data = 4'b0010;
        push_seq(2, 1'b0, 2);
        push_x(4'b1011, 4'b0010);
        push_end(K_HRDY, 1'b0, 1);
        start_seq(2);
        wait_host_ready("host_after_seq");
        tick();

        // Host write timing out
        c_ready = 1'b0;
        host_valid = 1'b1; host_addr = 4'b0101; host_data = 4'b1100;
        push_end(K_HRDY, 1'b1, 8);
        wait_host_ready("host_timeout");
        tick();
        chk("host_timeout_err", int'(err), 1);

        // Table write and start while busy are ignored
        c_ready = 1'b1;
        push_seq(3, 1'b0, 3);
        start_seq(3);
        tbl_we = 1'b1; tbl_idx = 3'd1; tbl_addr = 4'b1111; tbl_data = 4'b1111;
        start = 1'b1; tbl_len = 4'd1;
        tick();
        tbl_we = 1'b0; start = 1'b0;
        wait_idle("busy_ignore");
        push_seq(3, 1'b0, 3);
        start_seq(3);
        wait_idle("reread");

        // Empty sequence and length saturation
        push_seq(0, 1'b0, 0);
        start_seq(0);
        chk("len0_c_valid", int'(c_valid), 0);
        wait_idle("len0");
        push_seq(15, 1'b0, 8);
        start_seq(15);
        wait_idle("saturate");

        // Asynchronous reset mid-sequence
        c_ready = 1'b0;
        start_seq(3);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_c_valid", int'(c_valid), 0);
        chk("arst_c_addr", int'(c_addr), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_err", int'(err), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < ENTRIES; i++) begin
            m_a[i] = '0; m_d[i] = '0;
        end
        repeat (4) tick();
        chk("arst_idle", int'(busy), 0);
        c_ready = 1'b1;
        push_seq(1, 1'b0, 1);
        start_seq(1);
        wait_idle("post_reset");

        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
